// File: rtl/pipe_control_unit.sv
// Pipelined MIPS control: decodes the ID instruction into a control word and carries it
// through ID/EX, EX/MEM and MEM/WB, with load-use stall, flush and freeze handling.
module pipe_control_unit #(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit HAZARD_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               flush_i,
  input  logic               freeze_i,
  output logic               stall_o,
  output logic [1:0]         ex_jump,
  output logic [1:0]         ex_branch,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic [2:0]         ex_alu_op,
  output logic               ex_illegal,
  output logic               mem_read,
  output logic               mem_write,
  output logic [2:0]         mem_size,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg
);

  typedef struct packed {
    logic [1:0] jump;
    logic [1:0] branch;
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       illegal;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
    logic       reg_write;
    logic       mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  unused_bits;

  assign opcode      = id_instr[31:26];
  assign funct       = id_instr[5:0];
  assign id_rs       = id_instr[21 +: REG_ADDR_W];
  assign id_rt       = id_instr[16 +: REG_ADDR_W];
  assign unused_bits = ^id_instr[15:6];

  ctrl_t dec;
  logic  id_uses_rt;

  always_comb begin
    dec        = BUBBLE;
    id_uses_rt = 1'b0;
    case (opcode)
      6'h00: begin
        dec.reg_dst   = 1'b1;
        dec.alu_op    = ALU_FUNCT;
        dec.reg_write = 1'b1;
        id_uses_rt    = 1'b1;
        if (funct == 6'h08) begin
          dec.jump      = 2'b01;
          dec.reg_write = 1'b0;
        end
      end
      6'h23, 6'h20, 6'h24, 6'h21, 6'h25: begin
        dec.alu_src    = 1'b1;
        dec.alu_op     = ALU_ADD;
        dec.mem_read   = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        case (opcode)
          6'h20:   dec.mem_size = 3'b101;
          6'h24:   dec.mem_size = 3'b001;
          6'h21:   dec.mem_size = 3'b110;
          6'h25:   dec.mem_size = 3'b010;
          default: dec.mem_size = 3'b000;
        endcase
      end
      6'h2B, 6'h28, 6'h29: begin
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.mem_write = 1'b1;
        id_uses_rt    = 1'b1;
        case (opcode)
          6'h28:   dec.mem_size = 3'b001;
          6'h29:   dec.mem_size = 3'b010;
          default: dec.mem_size = 3'b000;
        endcase
      end
      6'h04: begin
        dec.branch = 2'b01;
        dec.alu_op = ALU_SUB;
        id_uses_rt = 1'b1;
      end
      6'h05: begin
        dec.branch = 2'b11;
        dec.alu_op = ALU_SUB;
        id_uses_rt = 1'b1;
      end
      6'h08, 6'h0C, 6'h0D, 6'h0E: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        case (opcode)
          6'h0C:   dec.alu_op = ALU_AND;
          6'h0D:   dec.alu_op = ALU_OR;
          6'h0E:   dec.alu_op = ALU_XOR;
          default: dec.alu_op = ALU_ADD;
        endcase
      end
      6'h02: dec.jump = 2'b10;
      6'h03: begin
        dec.jump      = 2'b11;
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  ctrl_t                 id_ex;
  logic [REG_ADDR_W-1:0] id_ex_rt;
  mem_ctrl_t             ex_mem;
  wb_ctrl_t              mem_wb;
  logic                  hazard;

  // A load in EX whose destination feeds the ID instruction cannot be forwarded in time.
  always_comb begin
    hazard = 1'b0;
    if (id_ex.mem_read && (id_ex_rt != '0)) begin
      if ((id_ex_rt == id_rs) || ((id_ex_rt == id_rt) && id_uses_rt)) begin
        hazard = 1'b1;
      end
    end
  end

  assign stall_o = HAZARD_EN ? hazard : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex    <= BUBBLE;
      id_ex_rt <= '0;
      ex_mem   <= '0;
      mem_wb   <= '0;
    end else if (!freeze_i) begin
      if (flush_i || stall_o) begin
        id_ex    <= BUBBLE;
        id_ex_rt <= '0;
      end else begin
        id_ex    <= dec;
        id_ex_rt <= id_rt;
      end
      ex_mem.mem_read   <= id_ex.mem_read;
      ex_mem.mem_write  <= id_ex.mem_write;
      ex_mem.mem_size   <= id_ex.mem_size;
      ex_mem.reg_write  <= id_ex.reg_write;
      ex_mem.mem_to_reg <= id_ex.mem_to_reg;
      mem_wb.reg_write  <= ex_mem.reg_write;
      mem_wb.mem_to_reg <= ex_mem.mem_to_reg;
    end
  end

  assign ex_jump       = id_ex.jump;
  assign ex_branch     = id_ex.branch;
  assign ex_reg_dst    = id_ex.reg_dst;
  assign ex_alu_src    = id_ex.alu_src;
  assign ex_alu_op     = id_ex.alu_op;
  assign ex_illegal    = id_ex.illegal;
  assign mem_read      = ex_mem.mem_read;
  assign mem_write     = ex_mem.mem_write;
  assign mem_size      = ex_mem.mem_size;
  assign wb_reg_write  = mem_wb.reg_write;
  assign wb_mem_to_reg = mem_wb.mem_to_reg;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: hazard stall, load staging, flush, freeze,
// illegal opcode, asynchronous reset, and a second instance with hazard detection off.
module tb_pipe_control_unit;

  logic        clk;
  logic        rst;
  logic [31:0] id_instr;
  logic        flush_i;
  logic        freeze_i;

  logic        stall_o;
  logic [1:0]  ex_jump;
  logic [1:0]  ex_branch;
  logic        ex_reg_dst;
  logic        ex_alu_src;
  logic [2:0]  ex_alu_op;
  logic        ex_illegal;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_size;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;

  logic        n_stall;
  logic [1:0]  n_jump;
  logic [1:0]  n_branch;
  logic        n_reg_dst;
  logic        n_alu_src;
  logic [2:0]  n_alu_op;
  logic        n_illegal;
  logic        n_mem_read;
  logic        n_mem_write;
  logic [2:0]  n_mem_size;
  logic        n_reg_write;
  logic        n_mem_to_reg;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] LW_R2  = 32'h8C02_0000;
  localparam logic [31:0] LW_R0  = 32'h8C00_0000;
  localparam logic [31:0] ADD    = 32'h0044_1820; // add r3,r2,r4
  localparam logic [31:0] LB_R5  = 32'h8025_0000; // lb r5,0(r1)
  localparam logic [31:0] SW_R2  = 32'hAC22_0004; // sw r2,4(r1)
  localparam logic [31:0] ADDI_A = 32'h2062_0001; // addi r2,r3,1
  localparam logic [31:0] ADDI_B = 32'h2045_0001; // addi r5,r2,1
  localparam logic [31:0] BNE    = 32'h1422_0000;
  localparam logic [31:0] JAL    = 32'h0C00_0010;
  localparam logic [31:0] ILL    = 32'hFC00_0000;

  wire [9:0]  ex_word = {ex_jump, ex_branch, ex_reg_dst, ex_alu_src, ex_alu_op, ex_illegal};
  wire [16:0] all_out = {ex_word, mem_read, mem_write, mem_size, wb_reg_write, wb_mem_to_reg};
  wire [17:0] n_all   = {n_stall, n_jump, n_branch, n_reg_dst, n_alu_src, n_alu_op, n_illegal,
                         n_mem_read, n_mem_write, n_mem_size, n_reg_write, n_mem_to_reg};

  pipe_control_unit dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .flush_i(flush_i), .freeze_i(freeze_i),
    .stall_o(stall_o), .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_reg_dst(ex_reg_dst),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_illegal(ex_illegal),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg)
  );

  pipe_control_unit #(.HAZARD_EN(1'b0)) u_nohz (
    .clk(clk), .rst(rst), .id_instr(id_instr), .flush_i(flush_i), .freeze_i(freeze_i),
    .stall_o(n_stall), .ex_jump(n_jump), .ex_branch(n_branch), .ex_reg_dst(n_reg_dst),
    .ex_alu_src(n_alu_src), .ex_alu_op(n_alu_op), .ex_illegal(n_illegal),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .mem_size(n_mem_size),
    .wb_reg_write(n_reg_write), .wb_mem_to_reg(n_mem_to_reg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    id_instr = NOP;
    flush_i  = 1'b0;
    freeze_i = 1'b0;
    #12;
    chk("reset_outputs", {15'd0, all_out}, 32'd0);
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    chk("reset_nohz", {14'd0, n_all}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick;

    // load-use: LW r2 then ADD r3,r2,r4
    id_instr = LW_R2;
    tick;
    id_instr = ADD;
    #1;
    chk("lu_stall", {31'd0, stall_o}, 32'd1);
    chk("lu_nohz_stall", {31'd0, n_stall}, 32'd0);
    tick;
    chk("lu_bubble_ex", {22'd0, ex_word}, 32'd0);
    chk("lu_mem_read", {31'd0, mem_read}, 32'd1);
    chk("lu_stall_clear", {31'd0, stall_o}, 32'd0);
    chk("lu_nohz_add_ex", {29'd0, n_alu_op}, 32'd2);
    tick;
    chk("lu_add_alu_op", {29'd0, ex_alu_op}, 32'd2);
    chk("lu_add_reg_dst", {31'd0, ex_reg_dst}, 32'd1);
    chk("lu_wb", {30'd0, wb_reg_write, wb_mem_to_reg}, 32'd3);

    // LB through the pipe
    id_instr = LB_R5;
    tick;
    chk("lb_t1_alu_src", {31'd0, ex_alu_src}, 32'd1);
    chk("lb_t1_alu_op", {29'd0, ex_alu_op}, 32'd0);
    id_instr = NOP;
    tick;
    chk("lb_t2_mem_read", {31'd0, mem_read}, 32'd1);
    chk("lb_t2_mem_size", {29'd0, mem_size}, 32'd5);
    tick;
    chk("lb_t3_wb", {30'd0, wb_reg_write, wb_mem_to_reg}, 32'd3);

    // store after load, load of r0, immediate rt-destination
    id_instr = LW_R2;
    tick;
    id_instr = SW_R2;
    #1;
    chk("sw_after_lw_stall", {31'd0, stall_o}, 32'd1);
    tick;
    chk("sw_stall_clear", {31'd0, stall_o}, 32'd0);
    tick;
    chk("sw_ex", {30'd0, ex_alu_src, ex_reg_dst}, 32'd2);
    id_instr = LW_R0;
    tick;
    chk("sw_mem", {27'd0, mem_write, mem_read, mem_size}, 32'h10);
    id_instr = SW_R2;
    #1;
    chk("sw_after_lw_r0", {31'd0, stall_o}, 32'd0);
    id_instr = LW_R2;
    tick;
    id_instr = ADDI_A;
    #1;
    chk("addi_rt_match", {31'd0, stall_o}, 32'd0);
    id_instr = ADDI_B;
    #1;
    chk("addi_rs_match", {31'd0, stall_o}, 32'd1);
    tick;
    chk("addi_stall_clear", {31'd0, stall_o}, 32'd0);

    // BNE then flushed JAL
    id_instr = BNE;
    tick;
    chk("bne_branch", {30'd0, ex_branch}, 32'd3);
    chk("bne_alu_op", {29'd0, ex_alu_op}, 32'd1);
    id_instr = JAL;
    flush_i  = 1'b1;
    tick;
    chk("flush_bubble", {22'd0, ex_word}, 32'd0);
    flush_i  = 1'b0;
    id_instr = NOP;
    tick;
    chk("flush_no_jal", {30'd0, ex_jump}, 32'd0);

    // freeze for 3 cycles with a pending load-use and an ignored flush
    id_instr = LW_R2;
    tick;
    id_instr = ADD;
    freeze_i = 1'b1;
    flush_i  = 1'b1;
    #1;
    chk("frz_stall_valid", {31'd0, stall_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("frz_hold_ex", {22'd0, ex_word}, 32'h010); // LW: alu_src only
      chk("frz_hold_mem", {31'd0, mem_read}, 32'd0);
      chk("frz_hold_wb", {31'd0, wb_reg_write}, 32'd0);
      chk("frz_stall", {31'd0, stall_o}, 32'd1);
    end
    freeze_i = 1'b0;
    flush_i  = 1'b0;
    tick;
    chk("frz_rel_bubble", {22'd0, ex_word}, 32'd0);
    chk("frz_rel_mem", {31'd0, mem_read}, 32'd1);
    chk("frz_rel_wb", {30'd0, wb_reg_write, wb_mem_to_reg}, 32'd2);
    tick;
    chk("frz_rel_add", {29'd0, ex_alu_op}, 32'd2);
    chk("frz_rel_wb_load", {31'd0, wb_mem_to_reg}, 32'd1);

    // illegal opcode, then flushed illegal
    id_instr = ILL;
    tick;
    chk("illegal_word", {22'd0, ex_word}, 32'h001);
    flush_i = 1'b1;
    tick;
    chk("illegal_flushed", {31'd0, ex_illegal}, 32'd0);
    flush_i = 1'b0;

    // asynchronous reset mid-stream
    id_instr = LW_R2;
    tick;
    tick;
    id_instr = ADD;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {15'd0, all_out}, 32'd0);
    chk("async_rst_stall", {31'd0, stall_o}, 32'd0);
    tick;
    rst      = 1'b0;
    id_instr = LB_R5;
    tick;
    chk("post_rst_decode", {31'd0, ex_alu_src}, 32'd1);
    chk("post_rst_mem", {31'd0, mem_read}, 32'd0);
    chk("nohz_never_stall", {31'd0, n_stall}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
